// File: rtl/i2c_temp_target.sv
// I2C target exposing a temperature snapshot, an ID byte and a bank of writable
// registers behind a 4-bit auto-incrementing pointer.
`timescale 1ns/1ps
module i2c_temp_target #(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter logic [7:0] DEV_ID   = 8'hCB
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  config_out,
    output logic        busy,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data
);

    localparam logic [3:0] IDLE      = 4'd0,
                           ADDR      = 4'd1,
                           ADDR_ACK  = 4'd2,
                           PTR       = 4'd3,
                           PTR_ACK   = 4'd4,
                           WDATA     = 4'd5,
                           WDATA_ACK = 4'd6,
                           RDATA     = 4'd7,
                           RDATA_ACK = 4'd8,
                           WAIT      = 4'd9;

    logic [2:0]  scl_sync, sda_sync;
    logic [3:0]  state, bit_cnt, pointer;
    logic [7:0]  shreg, tx, rd_byte;
    logic [7:0]  regs [16];
    logic [15:0] snapshot;
    logic        rw, nack;

    // Stages [1:0] synchronize; stage [2] is the previous value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl_i};
            sda_sync <= {sda_sync[1:0], sda_i};
        end
    end

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, writable;

    assign scl_s     = scl_sync[1];
    assign scl_d     = scl_sync[2];
    assign sda_s     = sda_sync[1];
    assign sda_d     = sda_sync[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign writable  = (pointer >= 4'h3) && (pointer != 4'hB);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_byte = regs[pointer];
        case (pointer)
            4'h0:    rd_byte = snapshot[15:8];
            4'h1:    rd_byte = snapshot[7:0];
            4'h2:    rd_byte = 8'h00;
            4'hB:    rd_byte = DEV_ID;
            default: ;
        endcase
    end

    assign config_out = regs[3];

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            pointer  <= '0;
            shreg    <= '0;
            tx       <= '0;
            snapshot <= '0;
            rw       <= 1'b0;
            nack     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            // NOTE: the register bank is built from flops with a defined reset value, not RAM.
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (start_det) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                snapshot <= temp_in;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == DEV_ADDR) begin
                                    state  <= ADDR_ACK;
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    rw     <= shreg[0];
                                end else begin
                                    state <= WAIT;
                                    busy  <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                pointer <= shreg[3:0];
                                sda_oe  <= 1'b1;
                                state   <= PTR_ACK;
                            end else begin
                                if (writable) begin
                                    regs[pointer] <= shreg;
                                    wr_stb        <= 1'b1;
                                    wr_addr       <= pointer;
                                    wr_data       <= shreg;
                                end
                                pointer <= pointer + 4'd1;
                                sda_oe  <= 1'b1;
                                state   <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (rw) begin
                            state  <= RDATA;
                            tx     <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                        end else begin
                            state  <= PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        state  <= WDATA;
                        sda_oe <= 1'b0;
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state   <= RDATA_ACK;
                            sda_oe  <= 1'b0;
                            pointer <= pointer + 4'd1;
                        end else begin
                            tx      <= {tx[6:0], 1'b0};
                            sda_oe  <= ~tx[6];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) nack <= sda_s;
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (!nack) begin
                                state  <= RDATA;
                                tx     <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state  <= WAIT;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
